redux_imem_loader: RTL
======================

# redux_imem_loader

Program loader and instruction memory for the Redux-V core. It accepts a program as a stream of 8-bit instruction bytes over a valid/ready handshake and writes it into an internal instruction RAM. While loading, it holds the CPU. Once loading completes it releases the CPU and serves combinational instruction fetches, replacing the core's fixed instruction memory as the writer side of the fetch path.

## Interface
Parameters:
- ADDR_W, default 8: RAM address width; depth = 2**ADDR_W bytes.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  loader source offers in_data
- in_ready  out  1  loader can accept a byte this cycle
- in_data  in  8  instruction byte
- in_last  in  1  qualifies in_data as the final program byte
- endereco  in  8  CPU fetch address (PC)
- instrucao  out  8  fetched instruction byte
- cpu_hold  out  1  high while the CPU must hold its PC at 0
- load_done  out  1  program loaded; memory is read-only until the next rst
- load_count  out  ADDR_W+1  number of bytes accepted in the current load
- err_overflow  out  1  RAM filled without in_last being seen

## Operation
- States: LOAD, FILL, RUN. Reset enters LOAD.
- **LOAD:**
  - in_ready=1, cpu_hold=1.
  - Handshake = in_valid & in_ready at a rising edge.
  - On handshake: mem[wr_ptr] <= in_data, wr_ptr++, load_count++.
- **Leaving LOAD:**
  - Handshake with in_last=1, and wr_ptr was not the top address: go to FILL (or RUN when fill is compiled out).
  - Handshake on the top address (2**ADDR_W-1), with in_last=1: go to RUN. No FILL, no error.
  - Handshake on the top address, with in_last=0: go to RUN and set err_overflow=1.
- **FILL:**
  - in_ready=0, cpu_hold=1.
  - Each cycle: mem[wr_ptr] <= 8'h00 (NOP/zero), wr_ptr++.
  - After writing the top address, go to RUN.
  - load_count does not change.
- **RUN:**
  - in_ready=0, cpu_hold=0, load_done=1.
  - Stays in RUN until rst.
  - in_valid is ignored and memory is never written.
- **Read port:**
  - instrucao = mem[endereco[ADDR_W-1:0]], combinational, in every state.
  - Upper address bits above ADDR_W are ignored (address wraps).
  - Read of a location being written the same cycle returns the old value until the edge, then the new value.
- **Reset:**
  - Values: state=LOAD, wr_ptr=0, load_count=0, load_done=0, err_overflow=0, cpu_hold=1, in_ready=1.
  - RAM contents are not cleared by rst.
- **Reset mid-load or mid-fill:** returns to LOAD with count 0. Old bytes stay readable until overwritten.
- **rst and handshake in the same cycle:** rst wins; no write occurs.

## Timing
- Write latency: a byte accepted at edge N is readable via instrucao from just after edge N.
- in_ready is a pure decode of state. The source may hold in_valid indefinitely; there is no timeout.
- in_data and in_last must be stable while in_valid=1 and in_ready=0 (not required in this block, since in_ready never drops mid-LOAD).
- Last byte accepted at edge N with load_count becoming K < 2**ADDR_W:
  - FILL covers edges N+1 .. N+(2**ADDR_W-K).
  - RUN is entered at edge N+(2**ADDR_W-K).
  - cpu_hold falls and load_done rises at that same edge.
- Direct LOAD->RUN transition: cpu_hold falls and load_done rises at edge N+1 relative to... no — at edge N itself (the accepting edge).
- Minimum load: 1 byte. Zero-byte programs are not supported; stay in LOAD.

## Configuration
- REDUX_LOADER_FILL_EN
  - **Defined:** FILL state is present; every RAM location not loaded is zeroed before release, so the CPU never fetches stale or X data.
  - **Undefined:** FILL state is removed. The last handshake moves directly to RUN on that edge, and unloaded locations keep prior contents (X after power-up in simulation).

## Test plan
- rst, then load 8'h81, 8'h42, 8'h13 (in_last on 3rd) with FILL_EN:
  - mem[0..2]=81/42/13 and load_count=3.
  - 253 FILL cycles, then cpu_hold=0 and load_done=1.
  - endereco=3 -> instrucao=8'h00.
- Backpressure/gaps: in_valid pattern 1,0,0,1,1,0,1(last) with bytes 10,20,30,40 -> load_count=4, mem[0..3]=10/20/30/40, no extra writes.
- Overflow (ADDR_W=4): 16 bytes without in_last -> err_overflow=1, load_count=16, RUN at 16th handshake edge, no FILL cycles.
- In RUN, in_valid=1 with in_data=8'hFF for 10 cycles -> in_ready=0, memory and load_count unchanged.
- rst asserted during FILL:
  - load_count=0, in_ready=1, cpu_hold=1, and old bytes still readable.
  - New 1-byte load (8'h5A, last) overwrites mem[0].
- REDUX_LOADER_FILL_EN undefined: 2-byte load -> load_done=1 and cpu_hold=0 on the accepting edge of byte 2; mem[2] untouched.

Source files
------------

// File: rtl/redux_imem_loader.sv
// Redux-V program loader and byte-wide instruction RAM with combinational fetch.
// Define REDUX_LOADER_FILL_EN to zero unloaded RAM before releasing the CPU.
module redux_imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  input  logic [7:0]        endereco,
  output logic [7:0]        instrucao,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   load_count,
  output logic              err_overflow
);

`ifdef REDUX_LOADER_FILL_EN
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd2
  } state_e;
`endif

  localparam int DEPTH = 2 ** ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                rdy_q, hold_q, done_q;
  logic                we;
  logic [7:0]          wdata;
  logic [7:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   rd_addr;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    we      = 1'b0;
    wdata   = in_data;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          we    = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (ptr_q == '1) begin
            state_d = RUN;
            err_d   = !in_last;
          end else if (in_last) begin
`ifdef REDUX_LOADER_FILL_EN
            state_d = FILL;
`else
            state_d = RUN;
`endif
          end
        end
      end
`ifdef REDUX_LOADER_FILL_EN
      FILL: begin
        we    = 1'b1;
        wdata = 8'h00;
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == '1) state_d = RUN;
      end
`endif
      RUN: ;
      default: state_d = LOAD;
    endcase
  end

  // Handshake outputs are registered from the next state, so they decode state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == LOAD);
      hold_q  <= (state_d != RUN);
      done_q  <= (state_d == RUN);
    end
  end

  always_ff @(posedge clk) begin
    if (we && !rst) mem[ptr_q] <= wdata;
  end

  assign rd_addr      = ADDR_W'(endereco);
  assign instrucao    = mem[rd_addr];
  assign in_ready     = rdy_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_count   = cnt_q;
  assign err_overflow = err_q;

endmodule
